// File: rtl/scarv_cop_palu_mul_issue_if.sv
// +----------------------------------------------------------------------------+
// | scarv_cop_palu_mul_issue_if                                                |
// | Request, multiplier and response bundle for the packed-ALU multiply issue. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface scarv_cop_palu_mul_issue_if #(
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_rs1;
  logic [31:0]      req_rs2;
  logic [2:0]       req_pw;
  logic             req_high;
  logic             req_ncarry;
  logic [TAG_W-1:0] req_rd;

  logic             mul_start;
  logic [31:0]      mul_a;
  logic [31:0]      mul_b;
  logic [2:0]       mul_pw;
  logic             mul_high;
  logic             mul_ncarry;
  logic             mul_done;
  logic [31:0]      mul_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_rd;

  // Slave is the issue controller; master is its environment.
  modport slave (
    input  req_valid, req_rs1, req_rs2, req_pw, req_high, req_ncarry, req_rd,
    input  mul_done, mul_result, rsp_ready,
    output req_ready, mul_start, mul_a, mul_b, mul_pw, mul_high, mul_ncarry,
    output rsp_valid, rsp_data, rsp_rd
  );

  modport master (
    output req_valid, req_rs1, req_rs2, req_pw, req_high, req_ncarry, req_rd,
    output mul_done, mul_result, rsp_ready,
    input  req_ready, mul_start, mul_a, mul_b, mul_pw, mul_high, mul_ncarry,
    input  rsp_valid, rsp_data, rsp_rd
  );
endinterface

`default_nettype wire

// File: rtl/scarv_cop_palu_mul_issue.sv
// +----------------------------------------------------------------------------+
// | scarv_cop_palu_mul_issue                                                   |
// | Issue/capture controller in front of the shift-and-add multiplier.         |
// | Optional perf counters: SCARV_COP_MUL_ISSUE_PERF_EN.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module scarv_cop_palu_mul_issue #(
  parameter int TAG_W = 5
) (
  input  logic                       g_clk,
  input  logic                       g_reset,
  input  logic                       flush,
  scarv_cop_palu_mul_issue_if.slave  bus,
  output logic                       busy,
  output logic [15:0]                perf_ops,
  output logic [31:0]                perf_cycles
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      rs1_q, rs1_d;
  logic [31:0]      rs2_q, rs2_d;
  logic [2:0]       pw_q, pw_d;
  logic             high_q, high_d;
  logic             ncarry_q, ncarry_d;
  logic [TAG_W-1:0] rd_q, rd_d;
  logic [31:0]      data_q, data_d;

  logic             req_ready;
  logic             accept;
  logic             rsp_hs;

  assign req_ready = (state_q == IDLE) && !flush;
  assign accept    = bus.req_valid && req_ready;
  assign rsp_hs    = (state_q == RESP) && bus.rsp_ready;

  always_comb begin
    state_d  = state_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    pw_d     = pw_q;
    high_d   = high_q;
    ncarry_d = ncarry_q;
    rd_d     = rd_q;
    data_d   = data_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          rs1_d    = bus.req_rs1;
          rs2_d    = bus.req_rs2;
          pw_d     = bus.req_pw;
          high_d   = bus.req_high;
          ncarry_d = bus.req_ncarry;
          rd_d     = bus.req_rd;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (bus.mul_done && !flush) begin
          data_d  = bus.mul_result;
          state_d = RESP;
        end else if (flush && !bus.mul_done) begin
          state_d = DRAIN;
        end else if (flush && bus.mul_done) begin
          state_d = IDLE;
        end
      end
      // start must stay high until done, otherwise the multiplier counter desyncs
      DRAIN: begin
        if (bus.mul_done) begin
          state_d = IDLE;
        end
      end
      RESP: begin
        if (flush || bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q  <= IDLE;
      rs1_q    <= '0;
      rs2_q    <= '0;
      pw_q     <= '0;
      high_q   <= 1'b0;
      ncarry_q <= 1'b0;
      rd_q     <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      pw_q     <= pw_d;
      high_q   <= high_d;
      ncarry_q <= ncarry_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.mul_start  = (state_q == BUSY) || (state_q == DRAIN);
  assign bus.mul_a      = rs1_q;
  assign bus.mul_b      = rs2_q;
  assign bus.mul_pw     = pw_q;
  assign bus.mul_high   = high_q;
  assign bus.mul_ncarry = ncarry_q;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_data   = data_q;
  assign bus.rsp_rd     = rd_q;
  assign busy           = (state_q != IDLE);

`ifdef SCARV_COP_MUL_ISSUE_PERF_EN
  logic [15:0] ops_q, ops_d;
  logic [31:0] cycles_q, cycles_d;

  always_comb begin
    ops_d    = ops_q;
    cycles_d = cycles_q;
    if (rsp_hs) begin
      ops_d = ops_q + 16'd1;
    end
    if (bus.mul_start) begin
      cycles_d = cycles_q + 32'd1;
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      ops_q    <= '0;
      cycles_q <= '0;
    end else begin
      ops_q    <= ops_d;
      cycles_q <= cycles_d;
    end
  end

  assign perf_ops    = ops_q;
  assign perf_cycles = cycles_q;
`else
  logic unused_rsp_hs;
  assign unused_rsp_hs = rsp_hs;
  assign perf_ops      = '0;
  assign perf_cycles   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_scarv_cop_palu_mul_issue.sv
// +----------------------------------------------------------------------------+
// | tb_scarv_cop_palu_mul_issue                                                |
// | Directed self-checking bench with a counting multiplier model.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_scarv_cop_palu_mul_issue;

  logic        g_clk;
  logic        g_reset;
  logic        flush;
  logic        busy;
  logic [15:0] perf_ops;
  logic [31:0] perf_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  scarv_cop_palu_mul_issue_if #(.TAG_W(5)) bus ();

  scarv_cop_palu_mul_issue #(.TAG_W(5)) u_dut (
    .g_clk       (g_clk),
    .g_reset     (g_reset),
    .flush       (flush),
    .bus         (bus),
    .busy        (busy),
    .perf_ops    (perf_ops),
    .perf_cycles (perf_cycles)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  // Multiplier model: counter only advances while start is high and is never
  // cleared by start dropping, so an early start deassertion misaligns it.
  logic [2:0] m_ctr;
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset)            m_ctr <= 3'd0;
    else if (bus.mul_start) m_ctr <= bus.mul_done ? 3'd0 : m_ctr + 3'd1;
  end
  assign bus.mul_done   = bus.mul_start && (m_ctr == bus.mul_pw);
  assign bus.mul_result = bus.mul_done ? bus.mul_a * bus.mul_b : 32'h0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entered at +1ns of an IDLE cycle; leaves at +1ns of cycle 1.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] pw, input logic [4:0] rd);
    bus.req_valid  = 1'b1;
    bus.req_rs1    = a;
    bus.req_rs2    = b;
    bus.req_pw     = pw;
    bus.req_rd     = rd;
    bus.req_high   = 1'b0;
    bus.req_ncarry = 1'b0;
    @(negedge g_clk);
    chk("accept_ready", bus.req_ready, 1);
    @(posedge g_clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Leaves at the negedge of the first rsp_valid cycle.
  task automatic wait_rsp(input string t, input logic [2:0] pw,
                          input logic [4:0] rd, input logic [31:0] exp);
    int starts = 0;
    int lat = -1;
    bit rdy_seen = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge g_clk);
      if (bus.rsp_valid) begin
        lat = c;
        break;
      end
      if (bus.mul_start) starts++;
      if (bus.req_ready) rdy_seen = 1'b1;
      @(posedge g_clk); #1;
    end
    chk({t, "_start_cycles"}, 64'(starts), 64'(int'(pw) + 1));
    chk({t, "_latency"}, 64'(lat), 64'(int'(pw) + 2));
    chk({t, "_data"}, bus.rsp_data, exp);
    chk({t, "_rd"}, bus.rsp_rd, rd);
    chk({t, "_ready_low"}, rdy_seen | bus.req_ready, 0);
    chk({t, "_start_drop"}, bus.mul_start, 0);
  endtask

  // Handshake then confirm the IDLE gap; leaves at +1ns of the cycle after it.
  task automatic hs(input string t);
    bus.rsp_ready = 1'b1;
    @(posedge g_clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge g_clk);
    chk({t, "_idle_busy"}, busy, 0);
    chk({t, "_idle_ready"}, bus.req_ready, 1);
    @(posedge g_clk); #1;
  endtask

  task automatic run_op(input string t, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] pw, input logic [4:0] rd, input logic [31:0] exp);
    issue(a, b, pw, rd);
    wait_rsp(t, pw, rd, exp);
    hs(t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int starts;
    bit seen;
    bit bad;
    g_reset = 1'b1;
    flush = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_rs1 = '0;
    bus.req_rs2 = '0;
    bus.req_pw = '0;
    bus.req_high = 1'b0;
    bus.req_ncarry = 1'b0;
    bus.req_rd = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    @(negedge g_clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_mul_start", bus.mul_start, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mul_a", bus.mul_a, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_rd", bus.rsp_rd, 0);
    chk("rst_perf", {perf_ops, perf_cycles}, 0);
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    @(posedge g_clk); #1;

    // Basic op: 3*5, pw=4
    run_op("op1", 32'h3, 32'h5, 3'd4, 5'd7, 32'h0000000F);

    // Stalled response, request pending, then back-to-back accept after the gap
    issue(32'h3, 32'h5, 3'd4, 5'd7);
    wait_rsp("stall", 3'd4, 5'd7, 32'h0000000F);
    bus.req_valid = 1'b1;
    bus.req_rs1 = 32'h6;
    bus.req_rs2 = 32'h7;
    bus.req_pw = 3'd0;
    bus.req_rd = 5'd3;
    bad = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge g_clk); #1;
      @(negedge g_clk);
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hF || bus.rsp_rd !== 5'd7) bad = 1'b1;
      if (bus.req_ready !== 1'b0 || busy !== 1'b1) seen = 1'b1;
    end
    chk("stall_rsp_stable", bad, 0);
    chk("stall_no_accept", seen, 0);
    hs("stall");
    bus.req_valid = 1'b0;
    wait_rsp("b2b", 3'd0, 5'd3, 32'h0000002A);
    hs("b2b");

    // Flush in second BUSY cycle: drain, no response
    issue(32'h9, 32'h9, 3'd4, 5'd1);
    starts = 0;
    seen = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      flush = (c == 2);
      @(negedge g_clk);
      if (bus.mul_start) starts++;
      if (bus.rsp_valid) seen = 1'b1;
      @(posedge g_clk); #1;
    end
    flush = 1'b0;
    chk("drain_start_cycles", 64'(starts), 5);
    chk("drain_no_rsp", seen, 0);
    chk("drain_idle", busy, 0);
    run_op("after_drain", 32'h3, 32'h5, 3'd4, 5'd7, 32'h0000000F);

    // Flush coincident with done (pw=0)
    issue(32'h2, 32'h2, 3'd0, 5'd1);
    flush = 1'b1;
    @(negedge g_clk);
    chk("coinc_done", bus.mul_done, 1);
    @(posedge g_clk); #1;
    flush = 1'b0;
    @(negedge g_clk);
    chk("coinc_busy", busy, 0);
    chk("coinc_ready", bus.req_ready, 1);
    chk("coinc_no_rsp", bus.rsp_valid, 0);
    @(posedge g_clk); #1;

    // Asynchronous reset in cycle 3 of a pw=7 op
    issue(32'h1, 32'h1, 3'd7, 5'd2);
    @(posedge g_clk); #1;
    @(posedge g_clk); #1;
    @(negedge g_clk);
    chk("prerst_start", bus.mul_start, 1);
    g_reset = 1'b1;
    #1;
    chk("arst_start", bus.mul_start, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rsp_valid", bus.rsp_valid, 0);
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    @(negedge g_clk);
    chk("arst_ready", bus.req_ready, 1);
    @(posedge g_clk); #1;

    // Perf counters: three pw=2 ops plus one flushed pw=2 op
    run_op("perf1", 32'h2, 32'h3, 3'd2, 5'd4, 32'h6);
    run_op("perf2", 32'h4, 32'h5, 3'd2, 5'd5, 32'h14);
    run_op("perf3", 32'h10, 32'h10, 3'd2, 5'd6, 32'h100);
    issue(32'h7, 32'h7, 3'd2, 5'd8);
    flush = 1'b1;
    @(posedge g_clk); #1;
    flush = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge g_clk);
      if (bus.rsp_valid) seen = 1'b1;
      if (!busy) break;
      @(posedge g_clk); #1;
    end
    chk("perf_flush_idle", busy, 0);
    chk("perf_flush_no_rsp", seen, 0);
`ifdef SCARV_COP_MUL_ISSUE_PERF_EN
    chk("perf_ops", perf_ops, 3);
    chk("perf_cycles", perf_cycles, 12);
`else
    chk("perf_ops", perf_ops, 0);
    chk("perf_cycles", perf_cycles, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
